// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter slice.
//   SHIFT_W / SA_W : datapath and shift-amount widths
//   shift_op_t     : one shift operation (operand, amount, direction, fill)
//   ref_shift      : bit-level reference shift, used by the scoreboard
package shift_pkg;
  localparam int SHIFT_W = 32;
  localparam int SA_W    = 5;

  typedef struct packed {
    logic [SHIFT_W-1:0] data;
    logic [SA_W-1:0]    sa;
    logic               right;
    logic               arith;
  } shift_op_t;

  // Built bit by bit so that it does not share structure with the shifter.
  function automatic logic [SHIFT_W-1:0] ref_shift(shift_op_t op);
    logic [SHIFT_W-1:0] r;
    logic               fill;
    int                 src;
    r    = '0;
    fill = op.right & op.arith & op.data[SHIFT_W-1];
    for (int i = 0; i < SHIFT_W; i++) begin
      if (op.right) begin
        src = i + int'(op.sa);
        if (src < SHIFT_W) r[i] = op.data[src[4:0]];
        else               r[i] = fill;
      end else begin
        src = i - int'(op.sa);
        if (src >= 0) r[i] = op.data[src[4:0]];
        else          r[i] = 1'b0;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle of the shift arbiter.
//   req_*  : NREQ valid/ready request ports with packed per-requester operands
//   res_*  : single result port with valid/ready backpressure
//   master : requesters + result consumer;  slave : the arbiter
interface shift_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  import shift_pkg::*;

  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][SHIFT_W-1:0] req_data;
  logic [NREQ-1:0][SA_W-1:0]    req_sa;
  logic [NREQ-1:0]              req_right;
  logic [NREQ-1:0]              req_arith;
  logic                         res_valid;
  logic [SHIFT_W-1:0]           res_data;
  logic [IDW-1:0]               res_id;
  logic                         res_ready;

  modport master (
    output req_valid, req_data, req_sa, req_right, req_arith, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );
  modport slave (
    input  req_valid, req_data, req_sa, req_right, req_arith, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index this cycle (0..N-1)
//   gnt : one-hot grant of the first set req found circularly from ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shift.sv
// Combinational 32-bit barrel shifter.
//   sh           : result
//   data         : operand
//   shift_amount : 0..31
//   right        : 1 = right, 0 = left (logical, zero fill)
//   arithmetic   : right shifts fill with data[31]; ignored for left
module shift
  import shift_pkg::*;
(
  output logic [SHIFT_W-1:0] sh,
  input  logic [SHIFT_W-1:0] data,
  input  logic [SA_W-1:0]    shift_amount,
  input  logic               right,
  input  logic               arithmetic
);
  always_comb begin
    if (!right)         sh = data << shift_amount;
    else if (arithmetic) sh = $unsigned($signed(data) >>> shift_amount);
    else                sh = data >> shift_amount;
  end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter between NREQ requesters with round-robin arbitration and
// a single registered result stage with valid/ready backpressure.
//   clk, rst_n : clock, async active-low reset
//   bus        : request ports (req_*) and result port (res_*), slave side
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_arbiter_if.slave bus
);
  logic               res_valid_q, res_valid_d;
  logic [SHIFT_W-1:0] res_data_q,  res_data_d;
  logic [IDW-1:0]     res_id_q,    res_id_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;

  logic               can_accept;
  logic               accept;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gidx;
  shift_op_t          op;
  logic [SHIFT_W-1:0] sh;

  // The output slot is free when empty or being drained this cycle.
  assign can_accept = !res_valid_q || bus.res_ready;

  rr_arbiter #(.N(NREQ), .PW(IDW)) u_rr (
    .req (bus.req_valid & {NREQ{can_accept}}),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;

  // Grant is one-hot, so a priority loop is just an encoder + mux.
  always_comb begin
    gidx = '0;
    op   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx     = IDW'(i);
        op.data  = bus.req_data[i];
        op.sa    = bus.req_sa[i];
        op.right = bus.req_right[i];
        op.arith = bus.req_arith[i];
      end
    end
  end

  shift u_shift (
    .sh           (sh),
    .data         (op.data),
    .shift_amount (op.sa),
    .right        (op.right),
    .arithmetic   (op.arith)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      // Covers the drain-and-reload case too: no bubble.
      res_valid_d = 1'b1;
      res_data_d  = sh;
      res_id_d    = gidx;
      rr_ptr_d    = (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));
  a_no_gnt_stall : assert property (@(posedge clk) disable iff (!rst_n)
    !can_accept |-> (bus.req_ready == '0));
  a_hold_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (res_valid_q && !bus.res_ready) |=> ($stable(res_data_q) && $stable(res_id_q)));
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter (NREQ=4): accepted ops push their
// expected result; a negedge monitor pops and compares on each drained result.
module tb_shift_arbiter;
  import shift_pkg::*;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  shift_arbiter_if #(.NREQ(N)) bus ();
  shift_arbiter #(.NREQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] d;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_res [N];
  logic [N-1:0] acc_vec = '0;
  int          waits [N];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [4:0]  t2_sa  [6] = '{5'd4, 5'd8, 5'd31, 5'd31, 5'd31, 5'd0};
  logic        t2_r   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        t2_a   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] t2_exp [6] = '{32'h0FF0000F, 32'h0000FF00, 32'hFFFFFFFF,
                              32'h00000001, 32'h80000000, 32'hFF0000FF};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(int i, logic [31:0] d, logic [4:0] sa, logic r, logic a,
                        logic [31:0] e);
    bus.req_data[i]  = d;
    bus.req_sa[i]    = sa;
    bus.req_right[i] = r;
    bus.req_arith[i] = a;
    exp_res[i]       = e;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic set_rand(int i);
    shift_op_t op;
    op.data  = $urandom;
    op.sa    = 5'($urandom_range(0, 31));
    op.right = 1'($urandom_range(0, 1));
    op.arith = 1'($urandom_range(0, 1));
    set_op(i, op.data, op.sa, op.right, op.arith, ref_shift(op));
  endtask

  // Advance one cycle; requesters whose op was accepted drop valid.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_vec[i]) bus.req_valid[i] = 1'b0;
  endtask

  // Acceptor + monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      acc_vec = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d data %h, none expected",
                   bus.res_id, bus.res_data);
        end else begin
          e = sb.pop_front();
          check("res_data", bus.res_data, e.d);
          check("res_id", 32'(bus.res_id), 32'(e.id));
        end
      end
      acc_vec = bus.req_valid & bus.req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc_vec[i]) begin
          check("fair_wait", 32'(waits[i] <= N-1), 32'd1);
          waits[i] = 0;
          sb.push_back('{d: exp_res[i], id: i});
        end else if (bus.req_valid[i] && acc_vec != '0) begin
          waits[i]++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish by 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_sa    = '0;
    bus.req_right = '0;
    bus.req_arith = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_res[i] = '0;
    #1 rst_n = 1'b0;
    #11;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    check("rst_res_id", 32'(bus.res_id), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;

    // Single op, one-cycle latency.
    @(posedge clk); #1;
    set_op(0, 32'hFF0000FF, 5'd4, 1'b1, 1'b1, 32'hFFF0000F);
    #1 check("t1_ready", 32'(bus.req_ready), 32'd1);
    cycle();
    check("t1_valid", 32'(bus.res_valid), 32'd1);
    check("t1_data", bus.res_data, 32'hFFF0000F);
    check("t1_id", 32'(bus.res_id), 32'd0);

    // Shift semantics, rotating the issuing requester.
    for (int j = 0; j < 6; j++) begin
      set_op(j % N, 32'hFF0000FF, t2_sa[j], t2_r[j], t2_a[j], t2_exp[j]);
      cycle();
      check("t2_data", bus.res_data, t2_exp[j]);
      check("t2_id", 32'(bus.res_id), 32'(j % N));
    end

    // Two requesters continuously valid: strict alternation from 0.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) if (!bus.req_valid[i]) begin
        shift_op_t op;
        op = '{data: 32'hF000000F ^ 32'(k), sa: 5'(k + i), right: 1'b0, arith: 1'b0};
        set_op(i, op.data, op.sa, op.right, op.arith, ref_shift(op));
      end
      #1 check("t3_grant", 32'(bus.req_ready), (k % 2) ? 32'd2 : 32'd1);
      cycle();
      check("t3_id", 32'(bus.res_id), 32'(k % 2));
    end
    bus.req_valid = '0;
    cycle();

    // Backpressure: stall holds everything, release drains and reloads.
    set_op(0, 32'hFF0000FF, 5'd4, 1'b1, 1'b0, 32'h0FF0000F);
    set_op(1, 32'h12345678, 5'd4, 1'b0, 1'b0, 32'h23456780);
    #1 check("t4_first_grant", 32'(bus.req_ready), 32'd1);
    cycle();
    bus.res_ready = 1'b0;
    set_op(0, 32'h00000001, 5'd31, 1'b0, 1'b0, 32'h80000000);
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t4_stall_ready", 32'(bus.req_ready), 32'd0);
      check("t4_stall_valid", 32'(bus.res_valid), 32'd1);
      check("t4_stall_data", bus.res_data, 32'h0FF0000F);
      check("t4_stall_id", 32'(bus.res_id), 32'd0);
      cycle();
    end
    bus.res_ready = 1'b1;
    #1 check("t4_release_grant", 32'(bus.req_ready), 32'd2);
    cycle();
    check("t4_nobubble_valid", 32'(bus.res_valid), 32'd1);
    check("t4_nobubble_id", 32'(bus.res_id), 32'd1);
    check("t4_nobubble_data", bus.res_data, 32'h23456780);
    check("t4_next_grant", 32'(bus.req_ready), 32'd1);
    cycle();
    check("t4_last_id", 32'(bus.res_id), 32'd0);
    check("t4_last_data", bus.res_data, 32'h80000000);
    cycle();
    check("t4_drained", 32'(bus.res_valid), 32'd0);

    // Asynchronous reset while a result is held.
    set_op(0, 32'h000000F0, 5'd4, 1'b1, 1'b0, 32'h0000000F);
    set_op(1, 32'h00000F00, 5'd8, 1'b1, 1'b0, 32'h0000000F);
    cycle();
    check("t5_pre_valid", 32'(bus.res_valid), 32'd1);
    check("t5_pre_id", 32'(bus.res_id), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus.res_valid), 32'd0);
    check("t5_async_id", 32'(bus.res_id), 32'd0);
    bus.req_valid = '0;
    sb.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    set_op(0, 32'h80000000, 5'd1, 1'b1, 1'b1, 32'hC0000000);
    set_op(1, 32'h0000000F, 5'd4, 1'b0, 1'b0, 32'h000000F0);
    #1 check("t5_first_grant", 32'(bus.req_ready), 32'd1);
    cycle();
    check("t5_first_id", 32'(bus.res_id), 32'd0);
    cycle();
    check("t5_second_id", 32'(bus.res_id), 32'd1);
    cycle();
    check("t5_drained", 32'(bus.res_valid), 32'd0);

    // Random soak: random arrivals and random backpressure.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_rand(i);
      bus.res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.res_ready = 1'b1;
    for (int c = 0; c < 50 && bus.req_valid != '0; c++) cycle();
    cycle();
    cycle();
    check("soak_all_accepted", 32'(bus.req_valid), 32'd0);
    check("soak_sb_empty", 32'(sb.size()), 32'd0);
    check("soak_idle", 32'(bus.res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational 32-bit `shift` datapath between NREQ requesters, for example the ALU issue port and the mul/div sequencer. Each requester has a valid/ready request port; the arbiter is round-robin. The selected operands go through the shared `shift` instance, and the result is captured in one output register with valid/ready backpressure. The block sits between the issue/sequencer logic and writeback.

Parameters:
- NREQ, 2, number of requesters; legal values 2..4.
- IDW, $clog2(NREQ) (minimum 1), width of the requester ID on the result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is done outside the block.
- req_valid  in  NREQ  requester i holds an operation.
- req_ready  out  NREQ  one-hot grant; the op is accepted when req_valid[i] && req_ready[i].
- req_data  in  NREQ*32  operand; slice i is [32*i+31:32*i].
- req_sa  in  NREQ*5  shift amount, 0..31.
- req_right  in  NREQ  1 = right shift, 0 = left shift.
- req_arith  in  NREQ  1 = arithmetic (sign fill); ignored for left shifts.
- res_valid  out  1  the output register holds a result.
- res_data  out  32  shifted result.
- res_id  out  IDW  index of the requester that issued the op.
- res_ready  in  1  consumer accepts the result when res_valid && res_ready.

Behaviour:
- Reset values: res_valid=0, res_data=0, res_id=0, rr_ptr=0. req_ready is combinational and therefore 0 while res_valid=0 and no req_valid is set.
- can_accept = !res_valid || res_ready.
- req_ready is nonzero only when can_accept=1. It is then one-hot: the first i with req_valid[i]=1, searching circularly from rr_ptr.
- req_ready is combinational from req_valid, rr_ptr, res_valid and res_ready.
- A requester must hold req_valid and its operands stable until accepted. The arbiter never drops a request.
- On accept of requester g (cycle N), at the clock edge:
  - res_data <= shift(req_data[g], req_sa[g], req_right[g], req_arith[g]);
  - res_id <= g; res_valid <= 1;
  - rr_ptr <= (g+1) mod NREQ.
- Latency is 1 cycle: res_valid=1 in cycle N+1.
- Throughput is 1 op per cycle while res_ready=1.
- Simultaneous drain and accept (res_valid && res_ready plus a new grant) loads the new result; res_valid stays 1 with no bubble.
- Drain with no accept: res_valid <= 0. res_data and res_id hold their values and are don't-care.
- Stall (res_valid && !res_ready): all req_ready=0, and res_data, res_id and rr_ptr hold.
- No valid requests: rr_ptr holds.
- Fairness: with all NREQ requesters continuously valid and no stalls, each is granted exactly once every NREQ cycles.
- Shift semantics:
  - left: logical, zero fill.
  - right && !arith: zero fill.
  - right && arith: fill with data[31].
  - sa=0 passes data unchanged.
- Reset mid-operation (rst_n low at any time) immediately clears res_valid and rr_ptr. The pending result is lost, and requesters must re-present.
- Internal assertions:
  - req_ready is onehot0.
  - No grant while !can_accept.
  - res_data stable while res_valid && !res_ready.

Decomposition:
- Package shift_pkg:
  - constants SHIFT_W=32 and SA_W=5;
  - typedef shift_op_t {data, sa, right, arith};
  - function ref_shift for the scoreboard.
- Sub-module rr_arbiter #(N): inputs req and ptr, output one-hot gnt; combinational, reused elsewhere.
- The existing combinational `shift` module is instantiated once, with port order (sh, data, shift_amount, right, arithmetic), on the muxed operands.
- The output register, rr_ptr and handshake logic live in shift_arbiter.

Test Plan:
1. Single op: requester 0, data=FF0000FF, sa=4, right=1, arith=1, res_ready=1 → one cycle later res_valid=1, res_data=FFF0000F, res_id=0.
2. Shift semantics on data=FF0000FF:
   - logical right sa=4 → 0FF0000F;
   - left sa=8 → 0000FF00;
   - arithmetic right sa=31 → FFFFFFFF;
   - logical right sa=31 → 00000001;
   - left sa=31 → 80000000;
   - sa=0 → FF0000FF.
3. Round-robin: NREQ=2, both requesters valid for 6 cycles, res_ready=1 → grants 0,1,0,1,0,1; res_id follows the same sequence one cycle later.
4. Backpressure: res_ready=0 for 3 cycles with both requesters valid → req_ready=0 throughout, and res_data/res_id hold. When res_ready=1 returns, drain and accept happen in the same cycle with no bubble.
5. Reset mid-stream: assert rst_n=0 asynchronously while res_valid=1 → res_valid drops without a clock edge. After release, requester 0 wins first when both requesters are valid.
6. Random soak: NREQ=4, random valid/ready for 10k cycles → every op matches ref_shift with the correct id, none is lost or duplicated, and no requester waits more than 4 grants.
